// File: rtl/neural_result_buffer.sv
// Result buffer behind the neural core: ReLU + saturating requantization to int8,
// argmax over two lanes, and a first-word-fall-through FIFO with drop-on-full.
module neural_result_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [15:0]         in_data [2],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [7:0]          out_act [2],
    output logic                       out_class,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clear_ovf,
    output logic [15:0]                sat_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [7:0] act0;
        logic [7:0] act1;
        logic       cls;
    } entry_t;

    // Stage 1 combinational quantization
    logic [15:0] r_c   [2];
    logic [15:0] q_c   [2];
    logic [7:0]  act_c [2];
    logic [1:0]  sat_c;
    logic        cls_c;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            r_c[i]   = in_data[i][15] ? 16'd0 : in_data[i];
            q_c[i]   = r_c[i] >> SHIFT;
            sat_c[i] = (q_c[i] > 16'd127);
            act_c[i] = sat_c[i] ? 8'd127 : q_c[i][7:0];
        end
        cls_c = (act_c[1] > act_c[0]);
    end

    logic        s1_valid_q;
    logic [7:0]  s1_act_q [2];
    logic        s1_cls_q;
    logic [1:0]  s1_sat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_act_q[0] <= 8'd0;
            s1_act_q[1] <= 8'd0;
            s1_cls_q    <= 1'b0;
            s1_sat_q    <= 2'b00;
        end else begin
            s1_valid_q  <= in_valid;
            s1_act_q[0] <= act_c[0];
            s1_act_q[1] <= act_c[1];
            s1_cls_q    <= cls_c;
            s1_sat_q    <= sat_c;
        end
    end

    // Stage 2 FIFO control
    entry_t          mem_q [DEPTH];
    entry_t          head_q, head_d, wdata_c;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, overflow_q, overflow_d;
    logic [15:0]     sat_count_q, sat_count_d;
    logic [16:0]     sat_sum_c;
    logic            pop_c, full_c, wr_c, drop_c;

    always_comb begin
        pop_c    = out_valid_q && out_ready;
        full_c   = (count_q == CW'(DEPTH));
        wr_c     = s1_valid_q && (!full_c || pop_c);
        drop_c   = s1_valid_q && !wr_c;
        wdata_c  = {s1_act_q[0], s1_act_q[1], s1_cls_q};
        wr_ptr_d = wr_c  ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (!wr_c && pop_c) begin
            count_d = count_q - CW'(1);
        end

        // Head tracks the slot rd_ptr_d will point at; a write into that slot forwards.
        head_d = head_q;
        if (count_d != '0) begin
            head_d = (wr_c && (rd_ptr_d == wr_ptr_q)) ? wdata_c : mem_q[rd_ptr_d];
        end

        overflow_d = overflow_q;
        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end

        sat_sum_c   = {1'b0, sat_count_q} + 17'(s1_sat_q[0]) + 17'(s1_sat_q[1]);
        sat_count_d = sat_count_q;
        if (s1_valid_q) begin
            sat_count_d = sat_sum_c[16] ? 16'hFFFF : sat_sum_c[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            sat_count_q <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            out_valid_q <= (count_d != '0);
            overflow_q  <= overflow_d;
            sat_count_q <= sat_count_d;
        end
    end

    // Storage needs no reset; occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem_q[wr_ptr_q] <= wdata_c;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_act[0] = head_q.act0;
    assign out_act[1] = head_q.act1;
    assign out_class  = head_q.cls;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_neural_result_buffer.sv
// Directed bench for neural_result_buffer (DEPTH=8, SHIFT=4).
module tb_neural_result_buffer;

    localparam int unsigned DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] in_data [2];
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_act [2];
    logic               out_class;
    logic [3:0]         count;
    logic               overflow;
    logic               clear_ovf;
    logic [15:0]        sat_count;

    int ntests = 0;
    int nfail  = 0;

    neural_result_buffer #(.DEPTH(DEPTH), .SHIFT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_class (out_class),
        .count     (count),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int a0, a1;
        int e0, e1, ecls, esat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a0, input int a1);
        in_data[0] = 16'(a0);
        in_data[1] = 16'(a1);
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
    endtask

    initial begin
        // a0, a1 -> act0, act1, class, cumulative sat_count
        vecs[0] = '{-300,   1000,    0,  62, 1, 0};
        vecs[1] = '{4000,   2032,  127, 127, 0, 1};
        vecs[2] = '{32767,  32767, 127, 127, 0, 3};
        vecs[3] = '{0,      0,       0,   0, 0, 3};
        vecs[4] = '{-32768, 15,      0,   0, 0, 3};
        vecs[5] = '{2047,   2048,  127, 127, 0, 4};
        vecs[6] = '{16,     -1,      1,   0, 0, 4};
        vecs[7] = '{160,    176,    10,  11, 1, 4};
        vecs[8] = '{2048,   -5,    127,   0, 0, 5};

        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data[0] = 16'd0;
        in_data[1] = 16'd0;
        out_ready  = 1'b0;
        clear_ovf  = 1'b0;

        // Reset held with inputs toggling
        for (int i = 0; i < 6; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data[0] = 16'($urandom);
            in_data[1] = 16'($urandom);
            out_ready  = 1'($urandom_range(0, 1));
            step();
        end
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_out_act0", out_act[0], 0);
        chk("rst_out_class", out_class, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        step(); step(); step();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_count", count, 0);

        // Table: one result per vector, 2-cycle latency, popped on the next edge
        out_ready = 1'b1;
        for (int v = 0; v < 9; v++) begin
            send(vecs[v].a0, vecs[v].a1);
            step();
            chk($sformatf("v%0d_out_valid", v), out_valid, 1);
            chk($sformatf("v%0d_act0", v), out_act[0], vecs[v].e0);
            chk($sformatf("v%0d_act1", v), out_act[1], vecs[v].e1);
            chk($sformatf("v%0d_class", v), out_class, vecs[v].ecls);
            chk($sformatf("v%0d_sat_count", v), sat_count, vecs[v].esat);
            step();
            chk($sformatf("v%0d_out_valid_drop", v), out_valid, 0);
        end

        // Overflow: 10 inputs into an 8-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) send(16 * k, 0);
        step(); step();
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_sat_count", sat_count, 5);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("ovf_pop%0d_valid", k), out_valid, 1);
            chk($sformatf("ovf_pop%0d_act0", k), out_act[0], k);
            step();
        end
        chk("ovf_drained_valid", out_valid, 0);
        chk("ovf_drained_count", count, 0);
        out_ready = 1'b0;
        chk("ovf_sticky", overflow, 1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with a write and a pop on the same edge
        for (int k = 1; k <= 8; k++) send(16 * k, 0);
        step(); step();
        chk("full_count", count, 8);
        send(16 * 9, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("fullpop_count", count, 8);
        chk("fullpop_overflow", overflow, 0);
        out_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            chk($sformatf("fullpop_pop%0d_act0", k), out_act[0], k);
            step();
        end
        chk("fullpop_drained_valid", out_valid, 0);
        out_ready = 1'b0;

        // Reset mid-stream with an entry in stage 1
        for (int k = 1; k <= 5; k++) send(16 * k, 0);
        step(); step();
        chk("mid_count_pre", count, 5);
        send(16 * 6, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_async_count", count, 0);
        chk("mid_async_valid", out_valid, 0);
        chk("mid_async_sat", sat_count, 0);
        step();
        rst = 1'b1;
        step(); step();
        chk("mid_inflight_dropped", count, 0);
        chk("mid_inflight_valid", out_valid, 0);
        out_ready = 1'b1;
        send(48, 0);
        step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_act0", out_act[0], 3);
        chk("post_rst_count", count, 1);
        step();
        chk("post_rst_drained", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
